// File: rtl/rv_writeback.sv
// RISC-V writeback stage: holds one retiring instruction, writes ALU results the
// cycle after capture and load results when data memory completes, with stall and bypass.
module rv_writeback (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        x_valid_i,
  input  logic [4:0]  x_rd_i,
  input  logic [31:0] x_rd_value_i,
  input  logic        x_rd_write_i,
  input  logic        x_load_i,
  input  logic [2:0]  x_fun_i,
  input  logic [1:0]  x_dm_addr_i,
  input  logic [31:0] dm_data_l_i,
  input  logic        dm_load_done_i,
  output logic        w_stall_req_o,
  output logic [4:0]  w_rd_o,
  output logic [31:0] w_rd_value_o,
  output logic        w_rd_store_o,
  output logic        w_bypass_rd_write_o,
  output logic [31:0] w_bypass_rd_value_o
);

  localparam logic [0:0] IDLE      = 1'b0;
  localparam logic [0:0] WAIT_LOAD = 1'b1;

  logic [0:0]  state;
  logic        valid;
  logic [4:0]  rd;
  logic [31:0] value;
  logic        rd_write;
  logic        load;
  logic [2:0]  fun;
  logic [1:0]  addr;
  logic [31:0] last_value;

  logic        capture;
  logic        store;
  logic [31:0] load_value;
  logic [31:0] wr_value;

  // Funct3 encodings outside the five defined loads fall through to a full word.
  function automatic logic [31:0] extract_load(input logic [2:0] f, input logic [1:0] a,
                                               input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'b00:   b = d[7:0];
      2'b01:   b = d[15:8];
      2'b10:   b = d[23:16];
      default: b = d[31:24];
    endcase
    h = a[1] ? d[31:16] : d[15:0];
    case (f)
      3'b000:  extract_load = {{24{b[7]}}, b};
      3'b001:  extract_load = {{16{h[15]}}, h};
      3'b100:  extract_load = {24'h000000, b};
      3'b101:  extract_load = {16'h0000, h};
      default: extract_load = d;
    endcase
  endfunction

  // Stall, capture and regfile write selection.
  always_comb begin
    w_stall_req_o = (state == WAIT_LOAD) && !dm_load_done_i;
    capture       = x_valid_i && !w_stall_req_o;
    load_value    = extract_load(fun, addr, dm_data_l_i);
    if (valid && load) begin
      store    = (state == WAIT_LOAD) && dm_load_done_i && rd_write && (rd != 5'd0);
      wr_value = load_value;
    end else begin
      store    = valid && !load && rd_write && (rd != 5'd0);
      wr_value = value;
    end
    w_rd_store_o        = store;
    w_rd_o              = rd;
    w_rd_value_o        = store ? wr_value : last_value;
    w_bypass_rd_write_o = store;
    w_bypass_rd_value_o = w_rd_value_o;
  end

  // Stage register, FSM and last-written value.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      valid      <= 1'b0;
      rd         <= 5'd0;
      value      <= 32'd0;
      rd_write   <= 1'b0;
      load       <= 1'b0;
      fun        <= 3'd0;
      addr       <= 2'd0;
      last_value <= 32'd0;
    end else begin
      if (capture) begin
        valid    <= 1'b1;
        rd       <= x_rd_i;
        value    <= x_rd_value_i;
        rd_write <= x_rd_write_i;
        load     <= x_load_i;
        fun      <= x_fun_i;
        addr     <= x_dm_addr_i;
      end else if (!w_stall_req_o) begin
        valid <= 1'b0;
      end else begin
        valid <= valid;
      end
      if (store) begin
        last_value <= wr_value;
      end else begin
        last_value <= last_value;
      end
      case (state)
        IDLE: begin
          if (capture && x_load_i) state <= WAIT_LOAD;
          else                     state <= IDLE;
        end
        WAIT_LOAD: begin
          // A load accepted in the completion cycle keeps the FSM waiting.
          if (dm_load_done_i) state <= (capture && x_load_i) ? WAIT_LOAD : IDLE;
          else                state <= WAIT_LOAD;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_writeback.sv
// Self-checking bench for rv_writeback: directed table, hand sequences, random vs model.
module tb_rv_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        x_valid;
  logic [4:0]  x_rd;
  logic [31:0] x_rd_value;
  logic        x_rd_write;
  logic        x_load;
  logic [2:0]  x_fun;
  logic [1:0]  x_dm_addr;
  logic [31:0] dm_data;
  logic        dm_done;
  logic        w_stall_req;
  logic [4:0]  w_rd;
  logic [31:0] w_rd_value;
  logic        w_rd_store;
  logic        w_bypass_rd_write;
  logic [31:0] w_bypass_rd_value;

  int passed = 0;
  int total  = 0;

  rv_writeback dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .x_valid_i           (x_valid),
    .x_rd_i              (x_rd),
    .x_rd_value_i        (x_rd_value),
    .x_rd_write_i        (x_rd_write),
    .x_load_i            (x_load),
    .x_fun_i             (x_fun),
    .x_dm_addr_i         (x_dm_addr),
    .dm_data_l_i         (dm_data),
    .dm_load_done_i      (dm_done),
    .w_stall_req_o       (w_stall_req),
    .w_rd_o              (w_rd),
    .w_rd_value_o        (w_rd_value),
    .w_rd_store_o        (w_rd_store),
    .w_bypass_rd_write_o (w_bypass_rd_write),
    .w_bypass_rd_value_o (w_bypass_rd_value)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        load;
    logic [2:0]  fun;
    logic [1:0]  addr;
    logic [4:0]  rd;
    logic        rd_write;
    logic [31:0] value;
    logic [31:0] data;
    logic        exp_store;
    logic [31:0] exp_value;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic expect_out(input string tag, input logic st, input logic [4:0] rd,
                            input logic [31:0] val, input logic stall, input bit chk_val);
    chk({tag, " store"}, {31'd0, w_rd_store}, {31'd0, st});
    chk({tag, " bypass_write"}, {31'd0, w_bypass_rd_write}, {31'd0, st});
    chk({tag, " stall"}, {31'd0, w_stall_req}, {31'd0, stall});
    if (chk_val) begin
      chk({tag, " rd"}, {27'd0, w_rd}, {27'd0, rd});
      chk({tag, " value"}, w_rd_value, val);
      chk({tag, " bypass_value"}, w_bypass_rd_value, val);
    end
  endtask

  task automatic idle_inputs();
    x_valid = 1'b0; x_rd = 5'd0; x_rd_value = 32'd0; x_rd_write = 1'b0;
    x_load = 1'b0; x_fun = 3'd0; x_dm_addr = 2'd0; dm_done = 1'b0;
  endtask

  task automatic offer(input logic ld, input logic [2:0] f, input logic [1:0] a,
                       input logic [4:0] r, input logic rw, input logic [31:0] v);
    x_valid = 1'b1; x_load = ld; x_fun = f; x_dm_addr = a;
    x_rd = r; x_rd_write = rw; x_rd_value = v;
  endtask

  // Reference load extraction from the ISA rules, using shifts and offsets.
  function automatic logic [31:0] ref_load(input logic [2:0] f, input logic [1:0] a,
                                           input logic [31:0] d);
    logic [31:0] v;
    bit          sgn;
    sgn = (f[2] == 1'b0);
    if (f[1:0] == 2'd0) begin
      v = (d >> (8 * a)) & 32'h000000FF;
      if (sgn && v >= 32'd128) v = v + 32'hFFFFFF00;
    end else if (f[1:0] == 2'd1) begin
      v = (d >> (16 * a[1])) & 32'h0000FFFF;
      if (sgn && v >= 32'd32768) v = v + 32'hFFFF0000;
    end else begin
      v = d;
    end
    return v;
  endfunction

  vec_t vecs[$];

  // Model state: the instruction held in the stage, plus last written value and rd.
  bit          m_occ;
  logic        m_ld, m_rw;
  logic [4:0]  m_rd;
  logic [31:0] m_val, m_last_val;
  logic [2:0]  m_fun;
  logic [1:0]  m_addr;

  initial begin
    logic        e_st, e_stall;
    logic [31:0] e_val;

    rst = 1'b1; dm_data = 32'd0;
    idle_inputs();
    @(negedge clk); @(negedge clk);
    #1 expect_out("reset", 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    rst = 1'b0;
    @(negedge clk);

    // Directed table: each entry captured, then checked the following cycle.
    vecs.push_back('{1'b0, 3'd0,   2'd0,  5'd5,  1'b1, 32'hDEADBEEF, 32'h0,        1'b1, 32'hDEADBEEF});
    vecs.push_back('{1'b0, 3'd0,   2'd0,  5'd0,  1'b1, 32'h00001234, 32'h0,        1'b0, 32'h0});
    vecs.push_back('{1'b0, 3'd0,   2'd0,  5'd6,  1'b0, 32'h00000077, 32'h0,        1'b0, 32'h0});
    vecs.push_back('{1'b1, 3'b000, 2'b10, 5'd10, 1'b1, 32'h0,        32'h11803344, 1'b1, 32'hFFFFFF80});
    vecs.push_back('{1'b1, 3'b100, 2'b10, 5'd10, 1'b1, 32'h0,        32'h11803344, 1'b1, 32'h00000080});
    vecs.push_back('{1'b1, 3'b000, 2'b00, 5'd10, 1'b1, 32'h0,        32'h11803344, 1'b1, 32'h00000044});
    vecs.push_back('{1'b1, 3'b000, 2'b11, 5'd11, 1'b1, 32'h0,        32'h80000000, 1'b1, 32'hFFFFFF80});
    vecs.push_back('{1'b1, 3'b100, 2'b11, 5'd11, 1'b1, 32'h0,        32'hFF000000, 1'b1, 32'h000000FF});
    vecs.push_back('{1'b1, 3'b101, 2'b10, 5'd12, 1'b1, 32'h0,        32'h8001ABCD, 1'b1, 32'h00008001});
    vecs.push_back('{1'b1, 3'b001, 2'b00, 5'd12, 1'b1, 32'h0,        32'h8001ABCD, 1'b1, 32'hFFFFABCD});
    vecs.push_back('{1'b1, 3'b001, 2'b01, 5'd12, 1'b1, 32'h0,        32'h8001ABCD, 1'b1, 32'hFFFFABCD});
    vecs.push_back('{1'b1, 3'b001, 2'b11, 5'd12, 1'b1, 32'h0,        32'h8001ABCD, 1'b1, 32'hFFFF8001});
    vecs.push_back('{1'b1, 3'b010, 2'b11, 5'd13, 1'b1, 32'h0,        32'hCAFEF00D, 1'b1, 32'hCAFEF00D});
    vecs.push_back('{1'b1, 3'b011, 2'b01, 5'd13, 1'b1, 32'h0,        32'h12345678, 1'b1, 32'h12345678});
    vecs.push_back('{1'b1, 3'b110, 2'b10, 5'd13, 1'b1, 32'h0,        32'h87654321, 1'b1, 32'h87654321});
    vecs.push_back('{1'b1, 3'b111, 2'b11, 5'd13, 1'b1, 32'h0,        32'h0F0F0F0F, 1'b1, 32'h0F0F0F0F});
    vecs.push_back('{1'b1, 3'b010, 2'b00, 5'd0,  1'b1, 32'h0,        32'hAAAA5555, 1'b0, 32'h0});

    foreach (vecs[i]) begin
      offer(vecs[i].load, vecs[i].fun, vecs[i].addr, vecs[i].rd, vecs[i].rd_write, vecs[i].value);
      dm_data = vecs[i].data;
      @(negedge clk);
      idle_inputs();
      dm_done = vecs[i].load;
      #1 expect_out($sformatf("vec%0d", i), vecs[i].exp_store, vecs[i].rd,
                    vecs[i].exp_value, 1'b0, vecs[i].exp_store);
      @(negedge clk);
      idle_inputs();
      #1 expect_out($sformatf("vec%0d once", i), 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
      @(negedge clk);
    end

    // LB to x7, done three cycles after capture: two stall cycles, then one write.
    offer(1'b1, 3'b000, 2'b10, 5'd7, 1'b1, 32'd0);
    dm_data = 32'h11803344;
    @(negedge clk); idle_inputs();
    #1 expect_out("lb wait1", 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    @(negedge clk);
    #1 expect_out("lb wait2", 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    @(negedge clk); dm_done = 1'b1;
    #1 expect_out("lb done", 1'b1, 5'd7, 32'hFFFFFF80, 1'b0, 1'b1);
    @(negedge clk); dm_done = 1'b0;
    #1 expect_out("lb after", 1'b0, 5'd7, 32'hFFFFFF80, 1'b0, 1'b1);

    // Back-to-back: LW x3 completes while ALU x4 is offered.
    offer(1'b1, 3'b010, 2'b00, 5'd3, 1'b1, 32'd0);
    dm_data = 32'hCAFEF00D;
    @(negedge clk);
    offer(1'b0, 3'b000, 2'b00, 5'd4, 1'b1, 32'h00000055);
    dm_done = 1'b1;
    #1 expect_out("b2b x3", 1'b1, 5'd3, 32'hCAFEF00D, 1'b0, 1'b1);
    @(negedge clk); idle_inputs();
    #1 expect_out("b2b x4", 1'b1, 5'd4, 32'h00000055, 1'b0, 1'b1);
    @(negedge clk);

    // Completion with nothing waiting is ignored.
    dm_done = 1'b1;
    #1 expect_out("idle done", 1'b0, 5'd4, 32'h00000055, 1'b0, 1'b1);
    @(negedge clk); idle_inputs();

    // Reset during a pending load abandons it.
    offer(1'b1, 3'b010, 2'b00, 5'd9, 1'b1, 32'd0);
    dm_data = 32'h01020304;
    @(negedge clk); idle_inputs();
    #1 expect_out("rst load wait", 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0; dm_done = 1'b1;
    #1 expect_out("rst load done", 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    @(negedge clk); idle_inputs();

    // Randomized traffic against the model; model starts from the reset state.
    m_occ = 1'b0; m_ld = 1'b0; m_rw = 1'b0; m_rd = 5'd0; m_val = 32'd0;
    m_last_val = 32'd0; m_fun = 3'd0; m_addr = 2'd0;
    for (int c = 0; c < 600; c++) begin
      rst        = ($urandom_range(0, 59) == 0);
      x_valid    = ($urandom_range(0, 3) != 0);
      x_rd       = 5'($urandom_range(0, 7));
      x_rd_value = $urandom;
      x_rd_write = ($urandom_range(0, 4) != 0);
      x_load     = $urandom_range(0, 1);
      x_fun      = 3'($urandom_range(0, 7));
      x_dm_addr  = 2'($urandom_range(0, 3));
      dm_data    = $urandom;
      dm_done    = ($urandom_range(0, 2) == 0);

      e_stall = m_occ && m_ld && !dm_done;
      e_st    = 1'b0;
      e_val   = m_last_val;
      if (m_occ && m_rw && m_rd != 5'd0 && (!m_ld || dm_done)) begin
        e_st  = 1'b1;
        e_val = m_ld ? ref_load(m_fun, m_addr, dm_data) : m_val;
      end
      #1 expect_out($sformatf("rand%0d", c), e_st, m_rd, e_val, e_stall, 1'b1);

      if (rst) begin
        m_occ = 1'b0; m_rd = 5'd0; m_last_val = 32'd0;
      end else begin
        if (e_st) m_last_val = e_val;
        if (x_valid && !e_stall) begin
          m_occ = 1'b1; m_ld = x_load; m_rw = x_rd_write; m_rd = x_rd;
          m_val = x_rd_value; m_fun = x_fun; m_addr = x_dm_addr;
        end else if (!e_stall) begin
          m_occ = 1'b0;
        end
      end
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
